// File: rtl/fetch_redirect_unit.sv
// IF-stage PC owner: steers fetch from the D-stage branch/jump decision; a decision shows on f_pc one cycle later.
// stall freezes everything and drops the decision; f_hold freezes only the PC and parks one target until fetch resumes.
module fetch_redirect_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        f_hold,
  input  logic [2:0]  npc_op,
  input  logic        branch,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] f_pc,
  output logic        redirect,
  output logic        pending,
  output logic        misalign
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] target;
  logic [31:0] br_off;
  logic        fire;

  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = d_pc + 32'd4;
    case (npc_op)
      3'd1:    target = d_pc + 32'd4 + br_off;
      3'd2:    target = {d_pc[31:28], instr_index, 2'b00};
      3'd3:    target = rs_val;
      default: target = d_pc + 32'd4;
    endcase
  end

  // A not-taken conditional branch falls through as a plain sequential fetch.
  assign fire = !stall && ((npc_op == 3'd2) || (npc_op == 3'd3) ||
                           ((npc_op == 3'd1) && branch));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PC_RESET;
      tgt      <= 32'd0;
      pending  <= 1'b0;
      redirect <= 1'b0;
      misalign <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
    end else if (f_hold) begin
      redirect <= 1'b0;
      // Only the first target survives; a second one would be a branch in the delay slot.
      if (fire && !pending) begin
        tgt     <= target;
        pending <= 1'b1;
      end
    end else if (pending) begin
      pc       <= tgt;
      pending  <= 1'b0;
      redirect <= 1'b1;
      if (tgt[1:0] != 2'b00) misalign <= 1'b1;
    end else if (fire) begin
      pc       <= target;
      redirect <= 1'b1;
      if (target[1:0] != 2'b00) misalign <= 1'b1;
    end else begin
      pc       <= pc + STEP;
      redirect <= 1'b0;
    end
  end

  assign f_pc = pc;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: inputs change 1ns after a rising edge, outputs are checked there too.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, stall, f_hold, branch;
  logic [2:0]  npc_op;
  logic [31:0] d_pc, rs_val;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] f_pc;
  logic        redirect, pending, misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .f_hold(f_hold), .npc_op(npc_op),
    .branch(branch), .d_pc(d_pc), .imm16(imm16), .instr_index(instr_index),
    .rs_val(rs_val), .f_pc(f_pc), .redirect(redirect), .pending(pending),
    .misalign(misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; f_hold = 0; npc_op = 3'd0; branch = 0;
    d_pc = 32'd0; imm16 = 16'd0; instr_index = 26'd0; rs_val = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    tick(); tick();
    checks++; if (f_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got %h want %h", f_pc, 32'h0000_3000); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", redirect); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [2];
    exp_pc[0] = 32'h0000_3004; exp_pc[1] = 32'h0000_3008;
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (f_pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d got %h want %h", i, f_pc, exp_pc[i]); end
      checks++; if (redirect !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL seq_flags%0d got r=%b p=%b want 0 0", i, redirect, pending); end
    end
  endtask

  task automatic test_branch();
    npc_op = 3'd1; branch = 1; d_pc = 32'h0000_3004; imm16 = 16'hFFFE;
    tick();
    checks++; if (f_pc !== 32'h0000_3000) begin errors++; $display("FAIL taken_pc got %h want %h", f_pc, 32'h0000_3000); end
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL taken_redirect got %b want 1", redirect); end
    idle_inputs();
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL after_taken_redirect got %b want 0", redirect); end
    tick();
    checks++; if (f_pc !== 32'h0000_3008) begin errors++; $display("FAIL back_at_3008 got %h want %h", f_pc, 32'h0000_3008); end
    npc_op = 3'd1; branch = 0; d_pc = 32'h0000_3004; imm16 = 16'hFFFE;
    tick();
    checks++; if (f_pc !== 32'h0000_300C) begin errors++; $display("FAIL not_taken_pc got %h want %h", f_pc, 32'h0000_300C); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL not_taken_redirect got %b want 0", redirect); end
    idle_inputs();
  endtask

  task automatic test_jr_wrap();
    npc_op = 3'd3; rs_val = 32'hFFFF_FFFC;
    tick();
    checks++; if (f_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jr_pc got %h want %h", f_pc, 32'hFFFF_FFFC); end
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jr_redirect got %b want 1", redirect); end
    idle_inputs();
    tick();
    checks++; if (f_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc got %h want %h", f_pc, 32'h0000_0000); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL wrap_misalign got %b want 0", misalign); end
    npc_op = 3'd3; rs_val = 32'h0000_3002;
    tick();
    checks++; if (f_pc !== 32'h0000_3002) begin errors++; $display("FAIL misjr_pc got %h want %h", f_pc, 32'h0000_3002); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misjr_misalign got %b want 1", misalign); end
    idle_inputs();
    tick(); tick();
    checks++; if (f_pc !== 32'h0000_300A) begin errors++; $display("FAIL mis_step_pc got %h want %h", f_pc, 32'h0000_300A); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b want 1", misalign); end
  endtask

  task automatic test_back_to_back();
    npc_op = 3'd3; rs_val = 32'h0000_0100;
    tick();
    checks++; if (f_pc !== 32'h0000_0100) begin errors++; $display("FAIL b2b_first got %h want %h", f_pc, 32'h0000_0100); end
    rs_val = 32'h0000_0200;
    tick();
    checks++; if (f_pc !== 32'h0000_0200 || redirect !== 1'b1) begin errors++; $display("FAIL b2b_second got %h r=%b want %h r=1", f_pc, redirect, 32'h0000_0200); end
    idle_inputs();
    tick();
    checks++; if (f_pc !== 32'h0000_0204 || redirect !== 1'b0) begin errors++; $display("FAIL b2b_seq got %h r=%b want %h r=0", f_pc, redirect, 32'h0000_0204); end
  endtask

  task automatic test_hold_redirect();
    reset = 1; idle_inputs();
    tick();
    reset = 0;
    checks++; if (f_pc !== 32'h0000_3000 || misalign !== 1'b0) begin errors++; $display("FAIL rereset got %h m=%b want %h m=0", f_pc, misalign, 32'h0000_3000); end
    f_hold = 1; npc_op = 3'd2; instr_index = 26'h0000C10; d_pc = 32'h0000_3004;
    tick();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL hold_pending got %b want 1", pending); end
    checks++; if (f_pc !== 32'h0000_3000 || redirect !== 1'b0) begin errors++; $display("FAIL hold_frozen got %h r=%b want %h r=0", f_pc, redirect, 32'h0000_3000); end
    npc_op = 3'd3; rs_val = 32'h0000_5000;
    tick();
    checks++; if (f_pc !== 32'h0000_3000 || pending !== 1'b1) begin errors++; $display("FAIL hold_second_fire got %h p=%b want %h p=1", f_pc, pending, 32'h0000_3000); end
    npc_op = 3'd0;
    tick();
    checks++; if (f_pc !== 32'h0000_3000) begin errors++; $display("FAIL hold_third got %h want %h", f_pc, 32'h0000_3000); end
    f_hold = 0;
    tick();
    checks++; if (f_pc !== 32'h0000_3040) begin errors++; $display("FAIL release_pc got %h want %h", f_pc, 32'h0000_3040); end
    checks++; if (redirect !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL release_flags got r=%b p=%b want 1 0", redirect, pending); end
    tick();
    checks++; if (f_pc !== 32'h0000_3044 || redirect !== 1'b0) begin errors++; $display("FAIL release_seq got %h r=%b want %h r=0", f_pc, redirect, 32'h0000_3044); end
  endtask

  task automatic test_pending_beats_fire();
    f_hold = 1; npc_op = 3'd2; instr_index = 26'h0000D00; d_pc = 32'h0000_3044;
    tick();
    checks++; if (f_pc !== 32'h0000_3044 || pending !== 1'b1) begin errors++; $display("FAIL pbf_latch got %h p=%b want %h p=1", f_pc, pending, 32'h0000_3044); end
    f_hold = 0; npc_op = 3'd3; rs_val = 32'h0000_7000;
    tick();
    checks++; if (f_pc !== 32'h0000_3400 || redirect !== 1'b1) begin errors++; $display("FAIL pbf_apply got %h r=%b want %h r=1", f_pc, redirect, 32'h0000_3400); end
    idle_inputs();
    tick();
    checks++; if (f_pc !== 32'h0000_3404) begin errors++; $display("FAIL pbf_seq got %h want %h", f_pc, 32'h0000_3404); end
  endtask

  task automatic test_stall();
    stall = 1; f_hold = 1; npc_op = 3'd1; branch = 1; d_pc = 32'h0000_3404; imm16 = 16'h0010;
    tick();
    checks++; if (f_pc !== 32'h0000_3404 || pending !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL stall_hold got %h p=%b r=%b want %h 0 0", f_pc, pending, redirect, 32'h0000_3404); end
    idle_inputs();
    tick();
    checks++; if (f_pc !== 32'h0000_3408 || redirect !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL stall_release got %h r=%b p=%b want %h 0 0", f_pc, redirect, pending, 32'h0000_3408); end
    stall = 1; npc_op = 3'd3; rs_val = 32'h0000_9000;
    tick();
    checks++; if (f_pc !== 32'h0000_3408 || redirect !== 1'b0) begin errors++; $display("FAIL stall_only got %h r=%b want %h r=0", f_pc, redirect, 32'h0000_3408); end
    idle_inputs();
    tick();
    checks++; if (f_pc !== 32'h0000_340C) begin errors++; $display("FAIL stall_only_release got %h want %h", f_pc, 32'h0000_340C); end
  endtask

  task automatic test_reset_pending();
    f_hold = 1; npc_op = 3'd2; instr_index = 26'h0000100; d_pc = 32'h0000_340C;
    tick();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rp_pending got %b want 1", pending); end
    idle_inputs(); reset = 1;
    tick();
    checks++; if (f_pc !== 32'h0000_3000 || pending !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL rp_reset got %h p=%b r=%b want %h 0 0", f_pc, pending, redirect, 32'h0000_3000); end
    reset = 0;
    tick();
    checks++; if (f_pc !== 32'h0000_3004 || redirect !== 1'b0) begin errors++; $display("FAIL rp_discard got %h r=%b want %h r=0", f_pc, redirect, 32'h0000_3004); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jr_wrap();
    test_back_to_back();
    test_hold_redirect();
    test_pending_beats_fire();
    test_stall();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Consumer side of the branch decision: owns the IF-stage PC register.
- Takes the D-stage taken/not-taken result plus jump info and steers the next fetch address. One architectural delay slot; the instruction at d_pc+4 is already in F.
- Absorbs fetch-side wait cycles: a redirect decided while fetch is held is latched and applied once fetch resumes.
- Sits between the hazard unit / D-stage branch logic and instruction memory.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit freeze of F and D; the D decision is not valid this cycle.
- f_hold  in  1  fetch-side wait (imem not ready). Freezes the PC only; D keeps advancing.
- npc_op  in  3  D-stage next-PC op: 0 = sequential, 1 = conditional branch, 2 = j/jal, 3 = jr/jalr, 4-7 = sequential.
- branch  in  1  taken flag from the D-stage branch comparator; meaningful only when npc_op = 1.
- d_pc  in  32  PC of the instruction in D.
- imm16  in  16  branch offset field.
- instr_index  in  26  jump index field.
- rs_val  in  32  forwarded rs value, used as the jr target.
- f_pc  out  32  current fetch address, driven straight from the PC register.
- redirect  out  1  registered; 1 for the cycle after the PC was loaded from a target.
- pending  out  1  registered; a target is latched and waiting for f_hold to drop.
- misalign  out  1  sticky; set when any loaded PC has [1:0] != 0.

Behaviour:
- Target computation (combinational, all arithmetic modulo 2^32):
  - op 1: d_pc + 4 + (sign_ext(imm16) << 2).
  - op 2: {d_pc[31:28], instr_index, 2'b00}.
  - op 3: rs_val.
- fire = !stall & ((npc_op == 2) | (npc_op == 3) | ((npc_op == 1) & branch)).
- Registers: pc, tgt, pending, redirect, misalign. Every clock edge follows this priority:
  1. reset: pc = PC_RESET, tgt = 0, pending = 0, redirect = 0, misalign = 0.
  2. stall: pc, tgt and pending hold; redirect = 0; any fire is ignored (stall dominates f_hold).
  3. f_hold (stall = 0): pc holds; redirect = 0.
     - If fire & !pending: tgt = target, pending = 1.
     - If fire & pending: the new target is dropped and pending stays 1. Illegal branch-in-delay-slot; no recovery required.
  4. Neither stall nor f_hold:
     - If pending: pc = tgt, pending = 0, redirect = 1. A simultaneous fire is ignored.
     - Else if fire: pc = target, redirect = 1.
     - Else: pc = pc + PC_STEP, redirect = 0.
- Wrap-around: pc = 32'hFFFF_FFFC followed by a sequential step gives 32'h0000_0000, with no flag.
- misalign is set in the same cycle as any pc load (target or tgt) whose value has [1:0] != 0.
  - The PC is still loaded with the misaligned value.
  - Cleared only by reset.
- Latency: the D-stage decision in cycle N appears on f_pc in cycle N+1, or on the first cycle after f_hold drops.
- The not-taken branch (op 1 & !branch) behaves as sequential.
- Reset mid-pending: pending clears and the latched target is discarded; the next f_pc is PC_RESET.

Test Plan:
- Sequential/reset: release reset with all inputs 0. f_pc steps 3000, 3004, 3008; redirect = 0 and pending = 0 throughout.
- Taken branch: at f_pc = 3008, drive npc_op = 1, branch = 1, d_pc = 3004, imm16 = 16'hFFFE. Next f_pc = 3000 with redirect = 1. Repeat with branch = 0: next f_pc = 300C.
- jr and wrap: npc_op = 3, rs_val = FFFF_FFFC. f_pc = FFFF_FFFC, then 0000_0000. Then rs_val = 0000_3002: f_pc = 3002 and misalign = 1, staying 1 until reset.
- Redirect under f_hold:
  - Hold f_hold = 1 for 3 cycles; in the first held cycle fire j with instr_index = 26'h0000C10 and d_pc = 3004. pending = 1 and f_pc is frozen.
  - Drop f_hold: next f_pc = 3040, redirect = 1, pending = 0.
  - A second fire (jr, any rs_val) while pending leaves tgt unchanged.
- Stall priority: assert stall = 1 together with f_hold = 1 and a taken branch. pc holds, pending stays 0, and no redirect follows once stall drops (if inputs return to op 0).
- Reset while pending = 1: the next cycle shows f_pc = 3000, pending = 0, redirect = 0.
